// File: rtl/alu_ctr_executor.sv
// Execution stage for the 3-bit alu_ctr code: single-cycle logic/arith ops plus an iterative shift-add multiply.
// Optional build macro MUL_EARLY_EXIT_EN lets a multiply finish as soon as the remaining multiplier bits are all zero.
module alu_ctr_executor #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       alu_ctr,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             slt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mplier_next;
    logic [CW-1:0]    count_next;
    logic             mul_last;
    logic             mul_trivial;

    always_comb begin
        sum     = operand_a + operand_b;
        diff    = operand_a - operand_b;
        slt     = $signed(operand_a) < $signed(operand_b);
        alu_res = '0;
        alu_ovf = 1'b0;
        case (alu_ctr)
            3'b000: alu_res = operand_a & operand_b;
            3'b001: alu_res = operand_a | operand_b;
            3'b010: begin
                alu_res = sum;
                alu_ovf = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                          (sum[WIDTH-1] != operand_a[WIDTH-1]);
            end
            3'b011: alu_res = operand_a ^ operand_b;
            3'b100: alu_res = ~(operand_a | operand_b);
            3'b101: alu_res = {{(WIDTH-1){1'b0}}, slt};
            3'b110: begin
                alu_res = diff;
                alu_ovf = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                          (diff[WIDTH-1] != operand_a[WIDTH-1]);
            end
            default: alu_res = '0;
        endcase
    end

    // One shift-add step; the final iteration's add is folded into the completing edge.
    always_comb begin
        acc_next    = acc + (mplier[0] ? mcand : '0);
        mplier_next = mplier >> 1;
        count_next  = count + 1'b1;
        mul_last    = (count_next == CW'(WIDTH));
`ifdef MUL_EARLY_EXIT_EN
        mul_last    = mul_last || (mplier_next == '0);
        mul_trivial = (operand_b == '0);
`else
        mul_trivial = 1'b0;
`endif
    end

    // A zero-multiplier MUL under early exit takes the single-cycle path, where alu_res is 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            count    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (alu_ctr == 3'b111 && !mul_trivial) begin
                            acc    <= '0;
                            mcand  <= operand_a;
                            mplier <= operand_b;
                            count  <= '0;
                            busy   <= 1'b1;
                            state  <= MUL;
                        end else begin
                            result   <= alu_res;
                            zero     <= (alu_res == '0);
                            overflow <= alu_ovf;
                            done     <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (mul_last) begin
                        result   <= acc_next;
                        zero     <= (acc_next == '0);
                        overflow <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        acc    <= acc_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier_next;
                        count  <= count_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
